// File: rtl/fwd_hazard_unit.sv
// Forwarding select and hazard (load-use, mult/div busy) control for the
// 5-stage MIPS core. Keeps its own copy of the EX/MEM/WB destination tags
// so the operand mux selects line up with the instruction sitting in EX.

// Per-operand forwarding select: picks the youngest in-flight producer.
module fwd_operand_sel #(
  parameter int REG_BITS = 5
) (
  input  logic                use_src,
  input  logic [REG_BITS-1:0] src,
  input  logic [REG_BITS-1:0] mem_dest,
  input  logic                mem_wr,
  input  logic                mem_load,
  input  logic [REG_BITS-1:0] wb_dest,
  input  logic                wb_wr,
  input  logic                wb_load,
  output logic [1:0]          sel
);

  // MEM beats WB; a load still in MEM has no data yet and is never a source.
  always_comb begin
    sel = 2'b00;
    if (use_src && src != '0) begin
      if (mem_wr && !mem_load && mem_dest == src)
        sel = 2'b01;
      else if (wb_wr && wb_dest == src)
        sel = wb_load ? 2'b11 : 2'b10;
    end
  end

endmodule

module fwd_hazard_unit #(
  parameter int REG_BITS   = 5,
  parameter int MD_LATENCY = 8,
  parameter int MD_CNT_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic [REG_BITS-1:0] id_dest,
  input  logic                id_wr,
  input  logic                id_load,
  input  logic                id_md_start,
  input  logic                id_md_read,
  input  logic                flush,
  output logic                stall,
  output logic [1:0]          fwd_sel_a,
  output logic [1:0]          fwd_sel_b,
  output logic                md_busy
);

  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic [REG_BITS-1:0] dest;
    logic                wr;
    logic                load;
  } slot_t;

  localparam slot_t BUBBLE = '{dest: '0, wr: 1'b0, load: 1'b0};

  slot_t               ex_q, mem_q, wb_q;
  logic [REG_BITS-1:0] ex_rs, ex_rt;
  logic                ex_use_rs, ex_use_rt;
  logic [MD_CNT_W-1:0] md_cnt;

  logic load_use, md_hazard, issue, md_accept;

  assign md_busy = (md_cnt != '0);

  // Load in EX whose result the ID instruction needs next cycle.
  always_comb begin
    load_use = 1'b0;
    if (id_valid && ex_q.wr && ex_q.load && ex_q.dest != '0)
      load_use = (id_use_rs && id_rs == ex_q.dest) ||
                 (id_use_rt && id_rt == ex_q.dest);
  end

  assign md_hazard = id_valid && md_busy && (id_md_start || id_md_read);
  assign stall     = (load_use || md_hazard) && !flush;
  assign issue     = id_valid && !stall && !flush;
  assign md_accept = issue && id_md_start;

  // Slot shift: ID enters EX only when issued, otherwise a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= BUBBLE;
      mem_q     <= BUBBLE;
      wb_q      <= BUBBLE;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_use_rs <= 1'b0;
      ex_use_rt <= 1'b0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (issue) begin
        ex_q      <= '{dest: id_dest, wr: id_wr, load: id_load};
        ex_rs     <= id_rs;
        ex_rt     <= id_rt;
        ex_use_rs <= id_use_rs;
        ex_use_rt <= id_use_rt;
      end else begin
        ex_q      <= BUBBLE;
        ex_rs     <= '0;
        ex_rt     <= '0;
        ex_use_rs <= 1'b0;
        ex_use_rt <= 1'b0;
      end
    end
  end

  // HI/LO occupancy countdown; reload only on an accepted mult/div.
  always_ff @(posedge clk) begin
    if (rst)
      md_cnt <= '0;
    else if (md_accept)
      md_cnt <= MD_CNT_W'(MD_LATENCY);
    else if (md_cnt != '0)
      md_cnt <= md_cnt - MD_CNT_W'(1);
  end

  logic [NUM_OPS-1:0]               op_use;
  logic [NUM_OPS-1:0][REG_BITS-1:0] op_src;
  logic [NUM_OPS-1:0][1:0]          op_sel;

  assign op_use = {ex_use_rt, ex_use_rs};
  assign op_src = {ex_rt, ex_rs};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    fwd_operand_sel #(.REG_BITS(REG_BITS)) u_sel (
      .use_src  (op_use[g]),
      .src      (op_src[g]),
      .mem_dest (mem_q.dest),
      .mem_wr   (mem_q.wr),
      .mem_load (mem_q.load),
      .wb_dest  (wb_q.dest),
      .wb_wr    (wb_q.wr),
      .wb_load  (wb_q.load),
      .sel      (op_sel[g])
    );
  end

  assign fwd_sel_a = op_sel[0];
  assign fwd_sel_b = op_sel[1];

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed program fragments plus a randomized
// instruction stream compared against an instruction-history model.
module tb_fwd_hazard_unit;

  localparam int MDL = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs, id_use_rt, id_wr, id_load;
  logic       id_md_start, id_md_read, flush;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       stall, md_busy;
  logic [1:0] fwd_sel_a, fwd_sel_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_BITS(5), .MD_LATENCY(MDL), .MD_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_wr(id_wr), .id_load(id_load), .id_md_start(id_md_start),
    .id_md_read(id_md_read), .flush(flush), .stall(stall),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .md_busy(md_busy)
  );

  typedef struct packed {
    logic       valid;
    logic [4:0] rs, rt;
    logic       ur, ut;
    logic [4:0] dest;
    logic       wr, ld, mds, mdr;
  } ins_t;

  // ---------------- reference model ----------------
  // The model remembers whole instructions as they go down the pipe and
  // tracks the mult/div unit as "busy until cycle md_end".
  ins_t m_ex = '0, m_mem = '0, m_wb = '0, cur_id;
  int   cyc = 0, md_end = 0;
  logic [1:0] exp_a, exp_b;
  logic       exp_stall, exp_busy;

  function automatic logic [1:0] producer_sel(input logic u, input logic [4:0] src,
                                              input ins_t mem, input ins_t wb);
    ins_t older [2];
    older[0] = mem;
    older[1] = wb;
    if (!u || src == 5'd0) return 2'b00;
    for (int d = 0; d < 2; d++) begin
      if (older[d].valid && older[d].wr && older[d].dest == src) begin
        if (older[d].ld) begin
          if (d == 1) return 2'b11;
        end else begin
          return (d == 0) ? 2'b01 : 2'b10;
        end
      end
    end
    return 2'b00;
  endfunction

  always_comb begin
    cur_id = '{valid: id_valid, rs: id_rs, rt: id_rt, ur: id_use_rs, ut: id_use_rt,
               dest: id_dest, wr: id_wr, ld: id_load, mds: id_md_start, mdr: id_md_read};
  end

  always_comb begin
    logic lu, md;
    exp_busy  = (cyc < md_end);
    lu = m_ex.valid && m_ex.ld && m_ex.wr && m_ex.dest != 5'd0 && id_valid &&
         ((id_use_rs && id_rs == m_ex.dest) || (id_use_rt && id_rt == m_ex.dest));
    md = id_valid && exp_busy && (id_md_start || id_md_read);
    exp_stall = (lu || md) && !flush;
    exp_a = producer_sel(m_ex.ur, m_ex.rs, m_mem, m_wb);
    exp_b = producer_sel(m_ex.ut, m_ex.rt, m_mem, m_wb);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_ex <= '0; m_mem <= '0; m_wb <= '0;
      md_end <= 0;
    end else begin
      m_wb  <= m_mem;
      m_mem <= m_ex;
      m_ex  <= (id_valid && !exp_stall && !flush) ? cur_id : '0;
      if (id_valid && id_md_start && !exp_stall && !flush) md_end <= cyc + 1 + MDL;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic ins_t nop();
    return '0;
  endfunction

  function automatic ins_t alu(input int d, input int s, input int t);
    ins_t i = '0;
    i.valid = 1; i.rs = 5'(s); i.rt = 5'(t); i.ur = 1; i.ut = 1;
    i.dest = 5'(d); i.wr = 1;
    return i;
  endfunction

  function automatic ins_t lw(input int d, input int base);
    ins_t i = '0;
    i.valid = 1; i.rs = 5'(base); i.ur = 1; i.dest = 5'(d); i.wr = 1; i.ld = 1;
    return i;
  endfunction

  function automatic ins_t mdop(input logic start);
    ins_t i = '0;
    i.valid = 1; i.rs = 5'd1; i.rt = 5'd2; i.ur = start; i.ut = start;
    i.mds = start; i.mdr = !start; i.wr = !start; i.dest = start ? 5'd0 : 5'd10;
    return i;
  endfunction

  task automatic drive(input ins_t i, input logic fl);
    id_valid = i.valid; id_rs = i.rs; id_rt = i.rt; id_use_rs = i.ur;
    id_use_rt = i.ut; id_dest = i.dest; id_wr = i.wr; id_load = i.ld;
    id_md_start = i.mds; id_md_read = i.mdr; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(nop(), 0);
    rst = 1;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall); end
    checks++; if (fwd_sel_a !== 2'b00) begin errors++; $display("FAIL reset_sel_a got=%b want=00", fwd_sel_a); end
    checks++; if (fwd_sel_b !== 2'b00) begin errors++; $display("FAIL reset_sel_b got=%b want=00", fwd_sel_b); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy got=%b want=0", md_busy); end
    tick();
  endtask

  task automatic test_fwd_mem();
    drive(alu(3, 1, 2), 0); tick();
    drive(alu(4, 3, 5), 0); tick();
    drive(nop(), 0);
    @(negedge clk);
    checks++; if (fwd_sel_a !== 2'b01) begin errors++; $display("FAIL mem_fwd_a got=%b want=01", fwd_sel_a); end
    checks++; if (fwd_sel_b !== 2'b00) begin errors++; $display("FAIL mem_fwd_b got=%b want=00", fwd_sel_b); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mem_fwd_stall got=%b want=0", stall); end
    tick(); tick(); tick();
  endtask

  task automatic test_fwd_wb();
    drive(alu(3, 1, 2), 0); tick();
    drive(alu(11, 12, 13), 0); tick();
    drive(alu(6, 7, 3), 0); tick();
    drive(nop(), 0);
    @(negedge clk);
    checks++; if (fwd_sel_b !== 2'b10) begin errors++; $display("FAIL wb_fwd_b got=%b want=10", fwd_sel_b); end
    checks++; if (fwd_sel_a !== 2'b00) begin errors++; $display("FAIL wb_fwd_a got=%b want=00", fwd_sel_a); end
    tick(); tick(); tick();
  endtask

  task automatic test_load_use();
    drive(lw(8, 1), 0); tick();
    drive(alu(9, 8, 8), 0);
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall1 got=%b want=1", stall); end
    tick();
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall2 got=%b want=0", stall); end
    checks++; if (fwd_sel_a !== 2'b00) begin errors++; $display("FAIL lu_bubble_a got=%b want=00", fwd_sel_a); end
    tick();
    drive(nop(), 0);
    @(negedge clk);
    checks++; if (fwd_sel_a !== 2'b11) begin errors++; $display("FAIL lu_fwd_a got=%b want=11", fwd_sel_a); end
    checks++; if (fwd_sel_b !== 2'b11) begin errors++; $display("FAIL lu_fwd_b got=%b want=11", fwd_sel_b); end
    tick(); tick(); tick();
  endtask

  task automatic test_priority_zero();
    drive(alu(3, 1, 2), 0); tick();
    drive(alu(3, 4, 5), 0); tick();
    drive(alu(7, 3, 3), 0); tick();
    drive(nop(), 0);
    @(negedge clk);
    checks++; if (fwd_sel_a !== 2'b01) begin errors++; $display("FAIL prio_a got=%b want=01", fwd_sel_a); end
    checks++; if (fwd_sel_b !== 2'b01) begin errors++; $display("FAIL prio_b got=%b want=01", fwd_sel_b); end
    tick();
    drive(alu(0, 1, 2), 0); tick();
    drive(alu(5, 0, 0), 0); tick();
    drive(nop(), 0);
    @(negedge clk);
    checks++; if (fwd_sel_a !== 2'b00) begin errors++; $display("FAIL zero_a got=%b want=00", fwd_sel_a); end
    checks++; if (fwd_sel_b !== 2'b00) begin errors++; $display("FAIL zero_b got=%b want=00", fwd_sel_b); end
    tick();
    drive(lw(0, 1), 0); tick();
    drive(alu(5, 0, 0), 0);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_lu_stall got=%b want=0", stall); end
    tick(); drive(nop(), 0); tick(); tick(); tick();
  endtask

  task automatic test_md();
    drive(mdop(1), 0); tick();
    drive(mdop(0), 0);
    for (int k = 0; k < MDL; k++) begin
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL md_stall[%0d] got=%b want=1", k, stall); end
      checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL md_busy[%0d] got=%b want=1", k, md_busy); end
      tick();
    end
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL md_release_stall got=%b want=0", stall); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL md_release_busy got=%b want=0", md_busy); end
    tick();
    drive(mdop(1), 0); tick();
    drive(mdop(1), 0);
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL md_second_start got=%b want=1", stall); end
    tick();
  endtask

  task automatic test_flush_and_reset();
    // md unit is still busy from test_md here
    drive(nop(), 0);
    @(negedge clk);
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got=%b want=1", md_busy); end
    rst = 1; tick(); rst = 0;
    @(negedge clk);
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rst_md_busy got=%b want=0", md_busy); end
    checks++; if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin
      errors++; $display("FAIL rst_sels got=%b/%b want=00/00", fwd_sel_a, fwd_sel_b); end
    tick();
    drive(lw(8, 1), 0); tick();
    drive(alu(9, 8, 2), 1);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b want=0", stall); end
    tick();
    drive(alu(12, 9, 0), 0); tick();
    drive(nop(), 0);
    @(negedge clk);
    checks++; if (fwd_sel_a !== 2'b00) begin errors++; $display("FAIL flush_bubble got=%b want=00", fwd_sel_a); end
    tick(); tick(); tick();
  endtask

  function automatic ins_t rand_ins();
    ins_t i;
    int   k = $urandom_range(0, 9);
    int   d = $urandom_range(0, 3), s = $urandom_range(0, 3), t = $urandom_range(0, 3);
    if (k <= 5) i = alu(d, s, t);
    else if (k <= 7) i = lw(d, s);
    else i = mdop(k == 8);
    if (k <= 5) begin i.ur = ($urandom_range(0, 3) != 0); i.ut = ($urandom_range(0, 1) != 0); end
    i.valid = ($urandom_range(0, 7) != 0);
    return i;
  endfunction

  task automatic test_random();
    ins_t cur = nop();
    logic held = 0;
    rst = 1; drive(nop(), 0); tick(); rst = 0;
    for (int n = 0; n < 800; n++) begin
      if (!held) cur = rand_ins();
      drive(cur, ($urandom_range(0, 15) == 0));
      @(negedge clk);
      checks++; if (stall !== exp_stall) begin errors++; $display("FAIL rnd_stall n=%0d got=%b want=%b", n, stall, exp_stall); end
      checks++; if (fwd_sel_a !== exp_a) begin errors++; $display("FAIL rnd_sel_a n=%0d got=%b want=%b", n, fwd_sel_a, exp_a); end
      checks++; if (fwd_sel_b !== exp_b) begin errors++; $display("FAIL rnd_sel_b n=%0d got=%b want=%b", n, fwd_sel_b, exp_b); end
      checks++; if (md_busy !== exp_busy) begin errors++; $display("FAIL rnd_md_busy n=%0d got=%b want=%b", n, md_busy, exp_busy); end
      held = exp_stall;
      tick();
    end
  endtask

  initial begin
    rst = 1;
    drive(nop(), 0);
    #1;
    test_reset();
    test_fwd_mem();
    test_fwd_wb();
    test_load_use();
    test_priority_zero();
    test_md();
    test_flush_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Generates the 2-bit select codes for the two ALU operand 4:1 muxes in EX (operand A, operand B) and the pipeline stall/bubble control for the 5-stage MIPS core.
- Tracks destination-register tags of in-flight instructions internally (EX, MEM, WB slots).
- Detects load-use hazards and multiply/divide busy hazards.
- Sits beside the ID/EX pipeline register; consumed by the operand muxes and the PC/IF/ID write enables.

Parameters:
- REG_BITS, 5, register-index width
- MD_LATENCY, 8, cycles a multiply/divide occupies HI/LO (≥1)
- MD_CNT_W, 4, width of the mult/div busy counter (must hold MD_LATENCY)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- id_valid  input  1  ID stage holds a real instruction
- id_rs  input  REG_BITS  source register 1 of ID instruction
- id_rt  input  REG_BITS  source register 2 of ID instruction
- id_use_rs  input  1  ID instruction reads rs
- id_use_rt  input  1  ID instruction reads rt
- id_dest  input  REG_BITS  destination register of ID instruction
- id_wr  input  1  ID instruction writes the register file
- id_load  input  1  ID instruction is a load
- id_md_start  input  1  ID instruction is mult/multu/div/divu
- id_md_read  input  1  ID instruction is mfhi/mflo
- flush  input  1  taken branch/jump resolved; squash ID instruction
- stall  output  1  hold PC and IF/ID, insert bubble into EX
- fwd_sel_a  output  2  operand-A mux select
- fwd_sel_b  output  2  operand-B mux select
- md_busy  output  1  mult/div unit occupied

Behaviour:
- Select encoding (both muxes):
  - 00: ID/EX register value
  - 01: EX/MEM ALU result
  - 10: MEM/WB ALU result
  - 11: MEM/WB load data
- Internal state: slots EX, MEM, WB, each holding {dest, wr, load}.
  - EX additionally holds {rs, rt, use_rs, use_rt}.
  - Busy counter md_cnt.
- Advance each clk:
  - WB<=MEM, MEM<=EX.
  - EX<=ID fields if id_valid & !stall & !flush; otherwise EX<=bubble (wr=0, load=0, use_rs=0, use_rt=0).
- Forwarding (combinational from registered slots), per operand X in {rs→A, rt→B}:
  - If EX.use_X=0 or EX.X==0 → 00.
  - Else if MEM.wr & MEM.dest==EX.X & !MEM.load → 01.
  - Else if WB.wr & WB.dest==EX.X → (WB.load ? 11 : 10).
  - Else → 00.
  - MEM takes priority over WB (youngest producer wins).
  - A MEM-slot load never forwards; the load-use stall guarantees it cannot occur.
- Load-use stall (combinational):
  - Asserted when id_valid & EX.wr & EX.load & EX.dest!=0 and EX.dest matches an ID source that is in use, i.e. (id_use_rs & id_rs==EX.dest) | (id_use_rt & id_rt==EX.dest).
  - Exactly one stall cycle per hazard; the bubble clears the condition.
- Mult/div:
  - md_busy = (md_cnt != 0).
  - Stall when id_valid & md_busy & (id_md_start | id_md_read).
  - md_cnt loads MD_LATENCY when id_valid & id_md_start & !stall & !flush; otherwise decrements while nonzero.
- stall = (load-use | md hazard) & !flush. flush overrides stall.
- Reset:
  - All slots become bubbles, md_cnt=0.
  - Outputs after reset: stall=0, fwd_sel_a=00, fwd_sel_b=00, md_busy=0.
  - Reset mid-mult/div aborts the busy period immediately.
- Register $0 is never forwarded and never causes a stall.
- Latency: selects are valid in the same cycle the consuming instruction occupies EX. No pipeline delay beyond the slot registers.

Test Plan:
- Reset, then `add $3,$1,$2` followed by `sub $4,$3,$5` → in the sub's EX cycle: fwd_sel_a=01, fwd_sel_b=00, stall=0.
- `add $3`, then an independent instruction, then `or $6,$7,$3` → or in EX: fwd_sel_b=10.
- `lw $8` then `add $9,$8,$8` → stall=1 for exactly one cycle with a bubble in EX. Next cycle fwd_sel_a=fwd_sel_b=11.
- `add $3`, then `add $3` again, then a reader of $3 one instruction later → fwd_sel=01 (MEM priority over WB). A writer to $0 followed by a reader of $0 → fwd_sel=00 and stall=0.
- `mult`, then `mflo` immediately → stall held for MD_LATENCY=8 cycles, md_busy deasserts, and mflo proceeds on the 9th cycle. A second `mult` while busy also stalls.
- A load-use hazard with flush=1 in the same cycle → stall=0 and EX gets a bubble. Asserting rst during md_busy → md_busy=0 on the next cycle and all selects=00.
